// File: rtl/hidden_seq_pkg.sv
// hidden_pkg: shared definitions for the time-multiplexed hidden layer.
//   state_t   - sequencer states (IDLE / MAC / DONE)
//   ACT_*     - activation select codes carried on i_mode
//   sat_s     - signed saturation of a wide value to a narrower signed width
package hidden_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ACT_LIN  = 2'd0;
  localparam logic [1:0] ACT_RELU = 2'd1;
  localparam logic [1:0] ACT_HSIG = 2'd2;

  // Widest value sat_s can take; callers sign-extend into this width.
  localparam int SAT_MAXW = 128;

  // Clamp v to the range of a w-bit signed number. The result is still
  // SAT_MAXW wide; the caller keeps the low w bits.
  function automatic logic signed [SAT_MAXW-1:0] sat_s(
    input logic signed [SAT_MAXW-1:0] v,
    input int unsigned                w
  );
    logic signed [SAT_MAXW-1:0] hi;
    logic signed [SAT_MAXW-1:0] lo;
    hi = $signed((SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1));
    lo = ~hi;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/hidden_seq_if.sv
// hidden_seq_if: weight-write port, input-vector handshake and result
// handshake of the hidden layer, bundled for the top-level port list.
//   wr/wr_addr/wr_data  weight/bias write port (entry j*(NUM_INPUT+1)+i)
//   i_mode              activation select, latched with the input vector
//   i_valid/i_ready/i_k input vector handshake
//   o_valid/o_ready/o   result vector handshake
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds valid and
// data stable until that edge; ready never depends combinationally on
// valid, and valid never depends combinationally on ready.
interface hidden_seq_if #(
  parameter int NUM_INPUT = 2,
  parameter int NUM_PCTN  = 2,
  parameter int WIDTH     = 32
);
  localparam int ADDR_W = $clog2(NUM_PCTN * (NUM_INPUT + 1));

  logic                          wr;
  logic [ADDR_W-1:0]             wr_addr;
  logic [WIDTH-1:0]              wr_data;
  logic [1:0]                    i_mode;
  logic                          i_valid;
  logic                          i_ready;
  logic [NUM_INPUT*WIDTH-1:0]    i_k;
  logic                          o_valid;
  logic                          o_ready;
  logic [NUM_PCTN*WIDTH-1:0]     o;

  modport master (
    output wr, wr_addr, wr_data, i_mode, i_valid, i_k, o_ready,
    input  i_ready, o_valid, o
  );

  modport slave (
    input  wr, wr_addr, wr_data, i_mode, i_valid, i_k, o_ready,
    output i_ready, o_valid, o
  );
endinterface

// File: rtl/hidden_seq_act_unit.sv
// act_unit: combinational post-processing of one perceptron sum.
//   acc_i  - full-precision accumulator (Q with 2*FRAC fractional bits)
//   mode_i - activation select (linear / ReLU / hard sigmoid; 3 = linear)
//   y_o    - activated result, WIDTH-bit signed Q(WIDTH-FRAC).FRAC
// Steps: arithmetic shift right by FRAC (truncating), saturate to WIDTH,
// then apply the activation.
module act_unit
  import hidden_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int ACC_W = 66
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic [1:0]              mode_i,
  output logic [WIDTH-1:0]        y_o
);
  localparam logic signed [WIDTH-1:0] ONE  = $signed({{(WIDTH-1){1'b0}}, 1'b1} << FRAC);
  localparam logic signed [WIDTH-1:0] HALF = $signed({{(WIDTH-1){1'b0}}, 1'b1} << (FRAC - 1));

  logic signed [ACC_W-1:0]    r_sh;
  logic signed [SAT_MAXW-1:0] r_ext;
  logic signed [SAT_MAXW-1:0] r_sat;
  logic signed [WIDTH-1:0]    r;
  logic signed [WIDTH-1:0]    hs;

  always_comb begin
    r_sh  = acc_i >>> FRAC;
    r_ext = {{(SAT_MAXW-ACC_W){r_sh[ACC_W-1]}}, r_sh};
    r_sat = sat_s(r_ext, WIDTH);
    r     = r_sat[WIDTH-1:0];
    // (r >>> 2) + 0.5 cannot overflow WIDTH because FRAC < WIDTH-2.
    hs    = (r >>> 2) + HALF;
    y_o   = r;
    case (mode_i)
      ACT_RELU: y_o = r[WIDTH-1] ? '0 : r;
      ACT_HSIG: begin
        if (hs < 0)        y_o = '0;
        else if (hs > ONE) y_o = ONE;
        else               y_o = hs;
      end
      default:  y_o = r;
    endcase
  end
endmodule

// File: rtl/hidden_seq.sv
// hidden_seq: hidden layer of NUM_PCTN perceptrons x NUM_INPUT inputs
// evaluated on one shared multiply-accumulate, one product per clock.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - hidden_seq_if slave: weight writes, input and result handshakes
//   state_o  - current sequencer state, for observation
// Weight file entry j*(NUM_INPUT+1)+i holds w[j][i]; i == NUM_INPUT is bias j.
module hidden_seq
  import hidden_pkg::*;
#(
  parameter int NUM_INPUT = 2,
  parameter int NUM_PCTN  = 2,
  parameter int WIDTH     = 32,
  parameter int FRAC      = 16
) (
  input  logic            clk,
  input  logic            rst,
  hidden_seq_if.slave     bus,
  output state_t          state_o
);
  localparam int NENT   = NUM_PCTN * (NUM_INPUT + 1);
  localparam int ADDR_W = $clog2(NENT);
  localparam int PW     = 2 * WIDTH;
  localparam int ACC_W  = PW + $clog2(NUM_INPUT + 1);
  localparam int IW     = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
  localparam int JW     = (NUM_PCTN  > 1) ? $clog2(NUM_PCTN)  : 1;

  state_t                     state_q, state_d;
  logic [WIDTH-1:0]           w_q [NENT];
  logic [NUM_INPUT*WIDTH-1:0] k_q;
  logic [1:0]                 mode_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic [IW-1:0]              i_q;
  logic [JW-1:0]              j_q;
  logic [NUM_PCTN*WIDTH-1:0]  o_q;

  logic                       last_i, last_j, we;
  logic [WIDTH-1:0]           k_sel, w_sel, b_next;
  logic [ADDR_W-1:0]          w_idx, b_idx;
  logic signed [PW-1:0]       prod;
  logic signed [ACC_W-1:0]    acc_sum, bias0_acc, bnext_acc;
  logic [WIDTH-1:0]           act_y;

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.i_valid)      state_d = ST_MAC;
      ST_MAC:  if (last_i && last_j) state_d = ST_DONE;
      ST_DONE: if (bus.o_ready)      state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // ---------------- MAC datapath ----------------
  always_comb begin
    last_i = (i_q == IW'(NUM_INPUT - 1));
    last_j = (j_q == JW'(NUM_PCTN - 1));
    k_sel  = k_q[int'(i_q)*WIDTH +: WIDTH];
    w_idx  = ADDR_W'(int'(j_q) * (NUM_INPUT + 1) + int'(i_q));
    w_sel  = w_q[w_idx];
    prod   = PW'($signed(k_sel)) * PW'($signed(w_sel));
    acc_sum = acc_q + ACC_W'(prod);
    // Bias is scaled by << FRAC so it lines up with the 2*FRAC product scale.
    bias0_acc = ACC_W'($signed(w_q[NUM_INPUT])) <<< FRAC;
    // Bias for the following perceptron; index held in range on the last one.
    b_idx = last_j ? ADDR_W'(NUM_INPUT)
                   : ADDR_W'((int'(j_q) + 1) * (NUM_INPUT + 1) + NUM_INPUT);
    b_next    = w_q[b_idx];
    bnext_acc = ACC_W'($signed(b_next)) <<< FRAC;
    // Writes are blocked during MAC so weights stay stable for a pass.
    we = bus.wr && (state_q != ST_MAC) && (int'(bus.wr_addr) < NENT);
  end

  act_unit #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_act (
    .acc_i  (acc_sum),
    .mode_i (mode_q),
    .y_o    (act_y)
  );

  // ---------------- State and data registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      for (int n = 0; n < NENT; n++) w_q[n] <= '0;
      k_q    <= '0;
      mode_q <= ACT_LIN;
      acc_q  <= '0;
      i_q    <= '0;
      j_q    <= '0;
      o_q    <= '0;
    end else begin
      state_q <= state_d;
      if (we) w_q[bus.wr_addr] <= bus.wr_data;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_valid) begin
            k_q    <= bus.i_k;
            mode_q <= bus.i_mode;
            // Reads bias0 before any same-edge write lands.
            acc_q  <= bias0_acc;
            i_q    <= '0;
            j_q    <= '0;
          end
        end
        ST_MAC: begin
          if (last_i) begin
            o_q[int'(j_q)*WIDTH +: WIDTH] <= act_y;
            acc_q <= bnext_acc;
            i_q   <= '0;
            j_q   <= last_j ? '0 : j_q + JW'(1);
          end else begin
            acc_q <= acc_sum;
            i_q   <= i_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.i_ready = (state_q == ST_IDLE);
  assign bus.o_valid = (state_q == ST_DONE);
  assign bus.o       = o_q;
  assign state_o     = state_q;

endmodule

// File: doc/hidden_seq.md
# hidden_seq

Time-multiplexed, parametrised hidden layer: one shared multiply-accumulate unit evaluates NUM_PCTN perceptrons of NUM_INPUT inputs each, one product per clock, in signed Q(WIDTH-FRAC).FRAC fixed point. Weights and biases live in an internal register file loaded through a write port. Results pass through a run-time-selectable activation and are presented with a valid/ready handshake. It replaces the fully parallel perceptron array where area matters more than latency, and feeds the output layer of the network datapath.

## Interface
- NUM_INPUT, 2, inputs per perceptron (≥1)
- NUM_PCTN, 2, perceptrons in the layer (≥1)
- WIDTH, 32, data/weight width, signed two's complement
- FRAC, 16, fractional bits (FRAC < WIDTH-2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr  in  1  weight/bias write strobe
- wr_addr  in  clog2(NUM_PCTN*(NUM_INPUT+1))  entry index j*(NUM_INPUT+1)+i; i==NUM_INPUT selects bias of perceptron j
- wr_data  in  WIDTH  value to write
- i_mode  in  2  activation: 0 linear, 1 ReLU, 2 hard sigmoid, 3 reserved (treated as linear)
- i_valid  in  1  input vector valid
- i_ready  out  1  block can accept a vector
- i_k  in  NUM_INPUT*WIDTH  input vector, element i at [i*WIDTH +: WIDTH]
- o_valid  out  1  result vector valid
- o_ready  in  1  consumer accepts result
- o  out  NUM_PCTN*WIDTH  activated outputs, perceptron j at [j*WIDTH +: WIDTH]

## Operation
- FSM states IDLE, MAC, DONE. Reset → IDLE; all weights/biases 0, o = 0, o_valid = 0, i_ready = 1, counters 0.
- IDLE: i_ready = 1. On i_valid && i_ready: latch i_k and i_mode, load acc ← sign-extended bias[0] << FRAC, j = 0, i = 0, go MAC.
- MAC: each cycle p = k[i]*w[j][i] (2·WIDTH-bit full product); acc += p. acc is 2·WIDTH+clog2(NUM_INPUT+1) bits, no internal overflow.
  - i < NUM_INPUT-1: i++.
  - i == NUM_INPUT-1: r = (acc+p) >>> FRAC (arithmetic, truncating), saturate to WIDTH signed, apply activation, write o[j]; reload acc ← bias[j+1] << FRAC, i = 0, j++. After j == NUM_PCTN-1 go DONE.
- Activation on saturated r: linear → r; ReLU → max(r,0); hard sigmoid → clamp((r >>> 2) + 0.5, 0, 1.0) with 0.5 = 1<<(FRAC-1), 1.0 = 1<<FRAC.
- DONE: o_valid = 1, i_ready = 0, o stable. On o_ready: o_valid ← 0, go IDLE.
- Writes: wr honoured in IDLE and DONE; ignored in MAC (weights are stable during a computation). wr_addr beyond last entry ignored. Write and input accept in the same IDLE cycle: write is committed, computation uses the old value for that entry only if the entry is bias[0] (loaded that edge); all other entries see the new value.
- o holds last result until overwritten during the next MAC pass; partially updated o during MAC is not valid.

## Timing
- Accept edge T → o_valid high from edge T+NUM_PCTN·NUM_INPUT; defaults: 4 cycles.
- Throughput: one vector per NUM_PCTN·NUM_INPUT+2 cycles with o_ready tied high (DONE cycle + IDLE cycle).
- i_ready is a registered state decode; no combinational path i_valid→i_ready or o_ready→o_valid.
- rst asserted mid-MAC or in DONE: immediate return to IDLE, o_valid = 0, o = 0, weights cleared; partial result discarded.

## Structure
- Package hidden_pkg: state encoding (IDLE/MAC/DONE), activation mode constants (ACT_LIN, ACT_RELU, ACT_HSIG), saturation helper function.
- Sub-module act_unit: combinational shift/saturate/activation of one accumulator value; instantiated once.
- Weight file: flat register array, NUM_PCTN·(NUM_INPUT+1) entries.

## Test plan
- Reset: assert rst mid-MAC → o_valid=0, i_ready=1, o=0 next cycle; reading computation afterward with no writes gives o=0.
- Linear, defaults: w[0]={1.0,2.0}, b0=0.5, w[1]={-1.0,0.5}, b1=0; k={0x00010000,0x00020000} → o0=0x00058000 (5.5), o1=0 after exactly 4 cycles.
- ReLU: same weights, mode 1, k={0x00030000,0} → o0=0x00038000, o1=0 (−3.0 clipped).
- Hard sigmoid: mode 2, acc result 4.0 → 0x00010000; result −4.0 → 0; result 0 → 0x00008000.
- Saturation: w=0x7FFF0000, k=0x7FFF0000, linear → o=0x7FFFFFFF; negative product → 0x80000000.
- Back-pressure/writes: hold o_ready=0 for 10 cycles → o_valid and o stable, i_ready=0; wr during MAC ignored (next result unchanged), wr in DONE applied to next vector.
